// File: rtl/des_key_sequencer.sv
// ---------------------------------------------------------------------------
// des_key_sequencer
//   Feeds 48-bit DES round keys to an iterative round datapath for single DES
//   or Triple-DES EDE. The user keys and mode are latched on start. One
//   subkey is presented per round, in the order the stage's direction needs,
//   and the sequencer steps on a valid/ack handshake.
//   des_roundkey: pure-wiring DES key schedule (PC-1, rotations, PC-2).
// ---------------------------------------------------------------------------
`default_nettype none

module des_roundkey (
  input  logic [63:0]       key_i,   // DES bit 1 is key_i[63]
  output logic [15:0][47:0] rk_o     // rk_o[r] is the key for round r+1
);
  localparam int PC1 [0:55] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                                10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
  localparam int PC2 [0:47] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                                23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                                41,52,31,37,47,55,30,40,51,45,33,48,
                                44,49,39,56,34,53,46,42,50,36,29,32};
  // Cumulative left-rotation of C and D before each round.
  localparam int ROT [0:15] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};

  logic [27:0] c0, d0;
  logic [55:0] c2, d2;

  for (genvar i = 0; i < 28; i++) begin : g_pc1
    assign c0[27-i] = key_i[64-PC1[i]];
    assign d0[27-i] = key_i[64-PC1[i+28]];
  end

  // Doubled halves so every rotation, including the full 28, is a part-select.
  assign c2 = {c0, c0};
  assign d2 = {d0, d0};

  for (genvar r = 0; r < 16; r++) begin : g_round
    logic [55:0] cd;
    assign cd = {c2[55-ROT[r] -: 28], d2[55-ROT[r] -: 28]};
    for (genvar j = 0; j < 48; j++) begin : g_pc2
      assign rk_o[r][47-j] = cd[56-PC2[j]];
    end
  end
endmodule

module des_key_sequencer #(
  parameter int NUM_STAGES = 3
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        mode,
  input  logic [63:0] key_1,
  input  logic [63:0] key_2,
  input  logic [63:0] key_3,
  input  logic        round_ack,
  input  logic        abort,
  output logic        busy,
  output logic        subkey_valid,
  output logic [47:0] subkey,
  output logic [1:0]  stage,
  output logic [3:0]  round_num,
  output logic        stage_decrypt,
  output logic        done
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

  state_t           state_q, state_d;
  logic [63:0]      k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic             mode_q, mode_d;
  logic [1:0]       stage_q, stage_d;
  logic [3:0]       round_q, round_d;
  logic             valid_q, valid_d;
  logic             dec_q, dec_d;
  logic [47:0]      subkey_q, subkey_d;
  logic [63:0]      key_sel;
  logic [15:0][47:0] rk;

  // EDE pattern: the middle stage runs opposite to the outer ones.
  function automatic logic stage_is_dec(input logic m, input logic [1:0] s);
    logic res;
    if (NUM_STAGES == 1) res = m;
    else                 res = (s == 2'd1) ? ~m : m;
    return res;
  endfunction

  // State and output registers; everything clears on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      k1_q     <= '0;
      k2_q     <= '0;
      k3_q     <= '0;
      mode_q   <= 1'b0;
      stage_q  <= '0;
      round_q  <= '0;
      valid_q  <= 1'b0;
      dec_q    <= 1'b0;
      subkey_q <= '0;
    end else begin
      state_q  <= state_d;
      k1_q     <= k1_d;
      k2_q     <= k2_d;
      k3_q     <= k3_d;
      mode_q   <= mode_d;
      stage_q  <= stage_d;
      round_q  <= round_d;
      valid_q  <= valid_d;
      dec_q    <= dec_d;
      subkey_q <= subkey_d;
    end
  end

  // Next-state: start/abort/ack handling and the stage/round walk.
  always_comb begin
    state_d = state_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    k3_d    = k3_q;
    mode_d  = mode_q;
    stage_d = stage_q;
    round_d = round_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k1_d    = key_1;
          k2_d    = key_2;
          k3_d    = key_3;
          mode_d  = mode;
          stage_d = 2'd0;
          round_d = stage_is_dec(mode, 2'd0) ? 4'd15 : 4'd0;
          valid_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          stage_d = 2'd0;
          round_d = 4'd0;
        end else if (round_ack) begin
          if (dec_q ? (round_q == 4'd0) : (round_q == 4'd15)) begin
            if (stage_q != LAST_STAGE) begin
              stage_d = stage_q + 2'd1;
              round_d = stage_is_dec(mode_q, stage_d) ? 4'd15 : 4'd0;
            end else begin
              state_d = S_DONE;
              valid_d = 1'b0;
              stage_d = 2'd0;
              round_d = 4'd0;
            end
          end else begin
            round_d = dec_q ? (round_q - 4'd1) : (round_q + 4'd1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Key feeding the schedule: chosen for the stage being entered next cycle.
  always_comb begin
    key_sel = k1_d;
    if (NUM_STAGES != 1) begin
      case (stage_d)
        2'd0:    key_sel = mode_d ? k3_d : k1_d;
        2'd1:    key_sel = k2_d;
        default: key_sel = mode_d ? k1_d : k3_d;
      endcase
    end
  end

  des_roundkey u_roundkey (
    .key_i (key_sel),
    .rk_o  (rk)
  );

  // Registered subkey mux and direction flag; zero while nothing is valid.
  always_comb begin
    dec_d    = valid_d & stage_is_dec(mode_d, stage_d);
    subkey_d = valid_d ? rk[round_d] : '0;
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DONE);
  assign done          = (state_q == S_DONE);
  assign subkey_valid  = valid_q;
  assign subkey        = subkey_q;
  assign stage         = stage_q;
  assign round_num     = round_q;
  assign stage_decrypt = dec_q;
endmodule

`default_nettype wire
